// File: rtl/cmul_pkg.sv
// Shared definitions for the pipelined complex multiplier: pipeline depth,
// rounding constant and the generalised symmetric saturation helper.
package cmul_pkg;

    localparam int PIPE_DEPTH = 3;
    localparam int CALC_W     = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        calc_t value;
        logic  flag;
    } sat_res_t;

    // Half an LSB of the output format when rounding, otherwise zero (floor).
    function automatic calc_t round_const(input int frac_bits, input int round_en);
        calc_t c;
        c = '0;
        if (round_en != 0) begin
            c = calc_t'(1) <<< (frac_bits - 1);
        end
        return c;
    endfunction

    // Clamp to [-(2^(w-1)-1), +(2^(w-1)-1)]; the asymmetric minimum is remapped too.
    function automatic sat_res_t sym_sat(input calc_t x, input int w);
        calc_t    max_v;
        sat_res_t r;
        max_v = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        if (x > max_v) begin
            r.value = max_v;
            r.flag  = 1'b1;
        end else if (x < -max_v) begin
            r.value = -max_v;
            r.flag  = 1'b1;
        end else begin
            r.value = x;
            r.flag  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmul_rnd_sat.sv
// One output component: optional round-half-up, arithmetic shift by FRAC_BITS,
// symmetric saturation and clip flag. Purely combinational.
module cmul_rnd_sat
    import cmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = DATA_WIDTH - 1,
    parameter int ROUND      = 1,
    parameter int IN_WIDTH   = 2 * DATA_WIDTH + 1
) (
    input  logic signed [IN_WIDTH-1:0]   x,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         flag
);

    localparam calc_t RND_CONST = round_const(FRAC_BITS, ROUND);

    calc_t    x_ext;
    calc_t    rounded;
    calc_t    shifted;
    sat_res_t res;
    logic     unused_hi;

    assign x_ext   = {{(CALC_W-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    assign rounded = x_ext + RND_CONST;
    assign shifted = rounded >>> FRAC_BITS;
    assign res     = sym_sat(shifted, DATA_WIDTH);

    // After saturation the upper bits are pure sign extension.
    assign y         = res.value[DATA_WIDTH-1:0];
    assign flag      = res.flag;
    assign unused_hi = ^res.value[CALC_W-1:DATA_WIDTH];

endmodule

// File: rtl/cmul_pipe.sv
// Three-stage pipelined complex multiplier (A*B or A*conj(B)) with a single
// global advance enable, valid/ready flow control and sticky saturation flag.
module cmul_pipe
    import cmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = DATA_WIDTH - 1,
    parameter int ROUND      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a_real,
    input  logic signed [DATA_WIDTH-1:0] a_imag,
    input  logic signed [DATA_WIDTH-1:0] b_real,
    input  logic signed [DATA_WIDTH-1:0] b_imag,
    input  logic                         conj,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] y_real,
    output logic signed [DATA_WIDTH-1:0] y_imag,
    output logic                         sat,
    output logic                         sat_sticky,
    input  logic                         clr_sat
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 1;

    logic                  en;
    logic [PIPE_DEPTH-1:0] valid_reg;

    logic signed [PW-1:0] ar_ext;
    logic signed [PW-1:0] ai_ext;
    logic signed [PW-1:0] br_ext;
    logic signed [PW-1:0] bi_ext;
    logic signed [PW-1:0] bi_eff;
    logic signed [PW-1:0] op_a      [4];
    logic signed [PW-1:0] op_b      [4];
    logic signed [PW-1:0] prod_next [4];
    logic signed [PW-1:0] prod_reg  [4];

    logic signed [SW-1:0] sum_next  [2];
    logic signed [SW-1:0] sum_reg   [2];

    logic signed [W-1:0]  y_next    [2];
    logic signed [W-1:0]  y_reg     [2];
    logic [1:0]           flag_next;
    logic                 sat_reg;
    logic                 sat_sticky_reg;

    assign en       = !valid_reg[PIPE_DEPTH-1] || out_ready;
    assign in_ready = en;

    // Operands are widened to 2W before negation so -(-2^(W-1)) cannot wrap.
    assign ar_ext = {{W{a_real[W-1]}}, a_real};
    assign ai_ext = {{W{a_imag[W-1]}}, a_imag};
    assign br_ext = {{W{b_real[W-1]}}, b_real};
    assign bi_ext = {{W{b_imag[W-1]}}, b_imag};
    assign bi_eff = conj ? -bi_ext : bi_ext;

    // Product order: ar*br, ai*bi, ar*bi, ai*br
    assign op_a[0] = ar_ext;
    assign op_b[0] = br_ext;
    assign op_a[1] = ai_ext;
    assign op_b[1] = bi_eff;
    assign op_a[2] = ar_ext;
    assign op_b[2] = bi_eff;
    assign op_a[3] = ai_ext;
    assign op_b[3] = br_ext;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_prod
            assign prod_next[gi] = op_a[gi] * op_b[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_reg[gi] <= '0;
                end else if (en) begin
                    prod_reg[gi] <= prod_next[gi];
                end
            end
        end
    endgenerate

    assign sum_next[0] = {prod_reg[0][PW-1], prod_reg[0]} - {prod_reg[1][PW-1], prod_reg[1]};
    assign sum_next[1] = {prod_reg[2][PW-1], prod_reg[2]} + {prod_reg[3][PW-1], prod_reg[3]};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_comp
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_reg[gi] <= '0;
                end else if (en) begin
                    sum_reg[gi] <= sum_next[gi];
                end
            end

            cmul_rnd_sat #(
                .DATA_WIDTH (W),
                .FRAC_BITS  (FRAC_BITS),
                .ROUND      (ROUND),
                .IN_WIDTH   (SW)
            ) u_rnd_sat (
                .x    (sum_reg[gi]),
                .y    (y_next[gi]),
                .flag (flag_next[gi])
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_reg[gi] <= '0;
                end else if (en) begin
                    y_reg[gi] <= y_next[gi];
                end
            end
        end
    endgenerate

    // Valid chain; sat is qualified so bubbles never carry a stray flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (en) begin
            valid_reg <= {valid_reg[PIPE_DEPTH-2:0], in_valid};
            sat_reg   <= valid_reg[PIPE_DEPTH-2] && (|flag_next);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_sticky_reg <= 1'b0;
        end else if (valid_reg[PIPE_DEPTH-1] && out_ready && sat_reg) begin
            sat_sticky_reg <= 1'b1;
        end else if (clr_sat) begin
            sat_sticky_reg <= 1'b0;
        end
    end

    assign out_valid  = valid_reg[PIPE_DEPTH-1];
    assign y_real     = y_reg[0];
    assign y_imag     = y_reg[1];
    assign sat        = sat_reg;
    assign sat_sticky = sat_sticky_reg;

endmodule
